// File: rtl/stream_pkg.sv
// Shared stream data-path definitions used by the arbiter and stream_fifo.
package stream_pkg;
    localparam int STREAM_WIDTH = 32;
    localparam int STREAM_FIFO_DEPTH = 4;

    typedef logic [STREAM_WIDTH-1:0] stream_word_t;
endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream plus occupancy status between the arbiter, stream_fifo and the sink.
interface stream_fifo_if
    import stream_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = STREAM_FIFO_DEPTH
);
    logic [WIDTH-1:0]           i_data;
    logic                       i_valid;
    logic                       o_ready;
    logic [WIDTH-1:0]           o_data;
    logic                       o_valid;
    logic                       i_ready;
    logic [$clog2(DEPTH+1)-1:0] o_level;
    logic                       o_full;
    logic                       o_empty;

    // slave is the FIFO side, master is the producer/sink side driving it
    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_level, o_full, o_empty
    );
    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_level, o_full, o_empty
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: DEPTH x WIDTH flops, sync write, async read.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none here; the parent only writes when an entry is free.
module stream_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO behind the arbiter; optional empty-bypass via STREAM_FIFO_BYPASS_EN.
// Latency: 1 cycle push-to-output (0 cycles when empty and bypass is built in).
// Backpressure: o_ready = !o_full, registered-derived, no combinational path from i_ready.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = STREAM_FIFO_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    stream_fifo_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [LW-1:0] lvl_t;

    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
    localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    lvl_t             level;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             byp;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

`ifdef STREAM_FIFO_BYPASS_EN
    // Reset must still force o_valid low even with a word waiting at the input.
    assign byp = empty && bus.i_valid && !i_rst;
`else
    assign byp = 1'b0;
`endif

    assign push  = bus.i_valid && !full;
    assign pop   = bus.o_valid && bus.i_ready;
    // A bypassed word that the sink takes at once never touches storage.
    assign wr_en = push && !(byp && bus.i_ready);
    assign rd_en = pop && !byp;

    assign bus.o_ready = !full;
    assign bus.o_valid = !empty || byp;
    assign bus.o_data  = byp ? bus.i_data : (empty ? '0 : rd_data);
    assign bus.o_level = level;
    assign bus.o_full  = full;
    assign bus.o_empty = empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_stream_fifo.sv
// Directed scoreboard bench for stream_fifo (DEPTH=4, WIDTH=32).
module tb_stream_fifo;
    import stream_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    stream_word_t exp_q[$];

    always #5 i_clk = ~i_clk;

    stream_fifo_if #(.WIDTH(32), .DEPTH(4)) sif ();

    stream_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (sif.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every output handshake pops the scoreboard and compares.
    always @(negedge i_clk) begin
        if (!i_rst && sif.o_valid === 1'b1 && sif.i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got=%0h required=no word @%0t", sif.o_data, $time);
            end else begin
                check("pop_data", sif.o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_word_t fill_w [4];
        int           budget;
        logic         phase;
        logic         acc;
        fill_w = '{32'h11, 32'h22, 32'h33, 32'h44};

        sif.i_valid = 1'b0;
        sif.i_data  = '0;
        sif.i_ready = 1'b0;
        #12;
        check("rst_level", 32'(sif.o_level), 0);
        check("rst_valid", 32'(sif.o_valid), 0);
        check("rst_ready", 32'(sif.o_ready), 1);
        check("rst_full",  32'(sif.o_full), 0);
        check("rst_empty", 32'(sif.o_empty), 1);
        check("rst_data",  sif.o_data, 0);
        i_rst = 1'b0;
        tick();

        // Fill with the sink stalled
        for (int k = 0; k < 4; k++) begin
            sif.i_valid = 1'b1;
            sif.i_data  = fill_w[k];
            exp_q.push_back(fill_w[k]);
            tick();
            check("fill_level", 32'(sif.o_level), 32'(k + 1));
        end
        check("fill_full",  32'(sif.o_full), 1);
        check("fill_ready", 32'(sif.o_ready), 0);
        sif.i_data = 32'h55;
        tick();
        check("full_hold_level", 32'(sif.o_level), 4);
        sif.i_valid = 1'b0;

        // Drain
        sif.i_ready = 1'b1;
        #1;
        check("drain_ready_pre", 32'(sif.o_ready), 0);
        tick();
        check("drain_ready_post", 32'(sif.o_ready), 1);
        check("drain_level1", 32'(sif.o_level), 3);
        tick();
        tick();
        tick();
        check("drain_empty", 32'(sif.o_empty), 1);
        check("drain_valid", 32'(sif.o_valid), 0);
        sif.i_ready = 1'b0;

        // Concurrent push/pop at level 2
        sif.i_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            sif.i_data = 32'(k);
            exp_q.push_back(32'(k));
            tick();
        end
        check("conc_level_start", 32'(sif.o_level), 2);
        sif.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sif.i_data = 32'hA0 + 32'(k);
            exp_q.push_back(32'hA0 + 32'(k));
            tick();
            check("conc_level", 32'(sif.o_level), 2);
        end
        sif.i_valid = 1'b0;
        tick();
        tick();
        check("conc_empty", 32'(sif.o_empty), 1);

        // Wrap: ten words with the sink toggling ready
        phase = 1'b1;
        for (int w = 0; w < 10; w++) begin
            sif.i_valid = 1'b1;
            sif.i_data  = 32'(w);
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 20) begin
                sif.i_ready = phase;
                phase = ~phase;
                acc = sif.o_ready;
                if (acc) exp_q.push_back(32'(w));
                tick();
                budget++;
            end
            if (!acc) check("wrap_accept_timeout", 0, 1);
        end
        sif.i_valid = 1'b0;
        sif.i_ready = 1'b1;
        budget = 0;
        while (sif.o_empty !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        check("wrap_empty", 32'(sif.o_empty), 1);
        check("wrap_sb_empty", 32'(exp_q.size()), 0);

        // Bypass case: empty FIFO, word offered with the sink ready
        sif.i_valid = 1'b1;
        sif.i_data  = 32'hDEAD;
        sif.i_ready = 1'b1;
        exp_q.push_back(32'hDEAD);
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        check("byp_valid_now", 32'(sif.o_valid), 1);
        check("byp_data_now", sif.o_data, 32'hDEAD);
        tick();
        sif.i_valid = 1'b0;
        check("byp_level", 32'(sif.o_level), 0);
`else
        check("nobyp_valid_now", 32'(sif.o_valid), 0);
        tick();
        sif.i_valid = 1'b0;
        #1;
        check("nobyp_valid_next", 32'(sif.o_valid), 1);
        check("nobyp_level", 32'(sif.o_level), 1);
        check("nobyp_data", sif.o_data, 32'hDEAD);
        tick();
        check("nobyp_level_after", 32'(sif.o_level), 0);
`endif
        sif.i_ready = 1'b0;

        // Reset mid-operation at level 3
        sif.i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sif.i_data = 32'hC0 + 32'(k);
            tick();
        end
        sif.i_valid = 1'b0;
        check("pre_rst_level", 32'(sif.o_level), 3);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(sif.o_valid), 0);
        check("mid_rst_level", 32'(sif.o_level), 0);
        check("mid_rst_ready", 32'(sif.o_ready), 1);
        check("mid_rst_data",  sif.o_data, 0);
        tick();
        i_rst = 1'b0;
        sif.i_valid = 1'b1;
        sif.i_data  = 32'h77;
        exp_q.push_back(32'h77);
        tick();
        sif.i_valid = 1'b0;
        sif.i_ready = 1'b1;
        check("post_rst_level", 32'(sif.o_level), 1);
        tick();
        check("post_rst_empty", 32'(sif.o_empty), 1);
        tick();
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
